// File: rtl/sar_search_8bit.sv
// Binary-search initiator for a magnitude comparator: drives trial values on A and
// narrows [lo, hi] from the less/equal/greater flags until it finds the value on B.
module sar_search_8bit #(
    parameter int WIDTH = 8,
    parameter int SW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             A_less_B,
    input  logic             A_equal_B,
    input  logic             A_great_B,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps
);
    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    localparam logic [WIDTH-1:0] MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [WIDTH-1:0] guess_q, guess_d, result_q, result_d;
    logic [SW-1:0]    steps_q, steps_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             found_q, found_d, err_q, err_d;

    logic [WIDTH-1:0] lo_n, hi_n;
    logic [WIDTH:0]   mid_sum;
    logic             fin;

    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        guess_d  = guess_q;
        result_d = result_q;
        steps_d  = steps_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;
        lo_n     = lo_q;
        hi_n     = hi_q;
        mid_sum  = '0;
        fin      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = MAX;
                    guess_d = MAX >> 1;
                    steps_d = '0;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = PROBE;
                end
            end
            PROBE: begin
                // Every probe cycle counts, including the one that terminates the search.
                steps_d = steps_q + SW'(1);
                case ({A_less_B, A_equal_B, A_great_B})
                    3'b010: begin
                        result_d = guess_q;
                        found_d  = 1'b1;
                        fin      = 1'b1;
                    end
                    3'b100: begin
                        if (guess_q == MAX) begin
                            err_d = 1'b1;
                            fin   = 1'b1;
                        end else begin
                            lo_n = guess_q + WIDTH'(1);
                        end
                    end
                    3'b001: begin
                        if (guess_q == '0) begin
                            err_d = 1'b1;
                            fin   = 1'b1;
                        end else begin
                            hi_n = guess_q - WIDTH'(1);
                        end
                    end
                    default: begin
                        err_d = 1'b1;
                        fin   = 1'b1;
                    end
                endcase

                if (!fin) begin
                    if (lo_n > hi_n) begin
                        err_d = 1'b1;
                        fin   = 1'b1;
                    end else begin
                        // One extra bit so lo+hi near 2*MAX cannot wrap.
                        mid_sum = {1'b0, lo_n} + {1'b0, hi_n};
                        guess_d = WIDTH'(mid_sum >> 1);
                        lo_d    = lo_n;
                        hi_d    = hi_n;
                    end
                end

                if (fin) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= MAX;
            guess_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign steps  = steps_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign err    = err_q;
endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench for sar_search_8bit with a behavioural comparator on the B side.
module tb_sar_search_8bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] target = 8'h00;
    logic       force_bad = 1'b0;
    logic [7:0] guess, result;
    logic       a_less, a_eq, a_gt;
    logic       busy, done, found, err;
    logic [3:0] steps;

    int checks = 0;
    int errors = 0;
    logic [7:0] rec [16];
    int nrec;
    int lat;

    logic [7:0] e_80 [8] = '{8'd127, 8'd191, 8'd159, 8'd143, 8'd135, 8'd131, 8'd129, 8'd128};
    logic [7:0] e_00 [8] = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
    logic [7:0] e_ff [9] = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
    logic [7:0] e_03 [6] = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3};

    sar_search_8bit #(.WIDTH(8), .SW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
        .A_less_B(a_less), .A_equal_B(a_eq), .A_great_B(a_gt),
        .busy(busy), .done(done), .found(found), .err(err),
        .result(result), .steps(steps)
    );

    always #5 clk = ~clk;

    always_comb begin
        a_less = guess < target;
        a_eq   = guess == target;
        a_gt   = guess > target;
        if (force_bad) begin
            a_less = 1'b1;
            a_eq   = 1'b1;
            a_gt   = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch a search and record guesses until done; lat = edges after the start edge.
    task automatic run(input logic [7:0] tgt, input bit hold);
        target = tgt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        nrec = 0;
        lat  = 0;
        rec[nrec++] = guess;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (nrec < 16) rec[nrec++] = guess;
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
            lat = 99;
        end
    endtask

    initial begin
        #12;
        chk("rst_guess", {24'd0, guess}, 32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_found", {31'd0, found}, 32'd0);
        chk("rst_err",   {31'd0, err},   32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_steps", {28'd0, steps}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0x80 with start held high through PROBE: sequence must be undisturbed
        run(8'h80, 1'b1);
        chk("t80_lat", lat, 32'd8);
        chk("t80_nrec", nrec, 32'd8);
        for (int i = 0; i < 8; i++) chk("t80_guess", {24'd0, rec[i]}, {24'd0, e_80[i]});
        chk("t80_found", {31'd0, found}, 32'd1);
        chk("t80_err", {31'd0, err}, 32'd0);
        chk("t80_result", {24'd0, result}, 32'd128);
        chk("t80_steps", {28'd0, steps}, 32'd8);
        // start still high in DONE -> immediate restart
        @(posedge clk);
        #1;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);
        chk("restart_guess", {24'd0, guess}, 32'd127);
        chk("restart_found_clr", {31'd0, found}, 32'd0);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        chk("restart_done_seen", {31'd0, done}, 32'd1);
        chk("restart_steps", {28'd0, steps}, 32'd8);
        chk("restart_result", {24'd0, result}, 32'd128);

        run(8'h00, 1'b0);
        chk("t00_lat", lat, 32'd8);
        chk("t00_nrec", nrec, 32'd8);
        for (int i = 0; i < 8; i++) chk("t00_guess", {24'd0, rec[i]}, {24'd0, e_00[i]});
        chk("t00_result", {24'd0, result}, 32'd0);
        chk("t00_found", {31'd0, found}, 32'd1);
        chk("t00_steps", {28'd0, steps}, 32'd8);

        run(8'hFF, 1'b0);
        chk("tff_lat", lat, 32'd9);
        chk("tff_nrec", nrec, 32'd9);
        for (int i = 0; i < 9; i++) chk("tff_guess", {24'd0, rec[i]}, {24'd0, e_ff[i]});
        chk("tff_result", {24'd0, result}, 32'd255);
        chk("tff_found", {31'd0, found}, 32'd1);
        chk("tff_steps", {28'd0, steps}, 32'd9);
        @(posedge clk);
        #1;
        chk("tff_done_pulse", {31'd0, done}, 32'd0);
        chk("tff_found_hold", {31'd0, found}, 32'd1);
        chk("tff_guess_hold", {24'd0, guess}, 32'd255);
        chk("tff_busy_done", {31'd0, busy}, 32'd0);

        run(8'h7F, 1'b0);
        chk("t7f_lat", lat, 32'd1);
        chk("t7f_result", {24'd0, result}, 32'd127);
        chk("t7f_found", {31'd0, found}, 32'd1);
        chk("t7f_steps", {28'd0, steps}, 32'd1);

        // two flags at once on the first probe
        force_bad = 1'b1;
        run(8'h40, 1'b0);
        force_bad = 1'b0;
        chk("bad_lat", lat, 32'd1);
        chk("bad_err", {31'd0, err}, 32'd1);
        chk("bad_found", {31'd0, found}, 32'd0);
        chk("bad_steps", {28'd0, steps}, 32'd1);
        @(posedge clk);
        #1;
        chk("bad_done_pulse", {31'd0, done}, 32'd0);
        chk("bad_err_hold", {31'd0, err}, 32'd1);

        // reset after the third probe
        target = 8'h10;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_steps", {28'd0, steps}, 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_guess", {24'd0, guess}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_steps", {28'd0, steps}, 32'd0);
        chk("arst_found_err", {30'd0, found, err}, 32'd0);
        chk("arst_result_done", {23'd0, result, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'h03, 1'b0);
        chk("t03_lat", lat, 32'd6);
        chk("t03_nrec", nrec, 32'd6);
        for (int i = 0; i < 6; i++) chk("t03_guess", {24'd0, rec[i]}, {24'd0, e_03[i]});
        chk("t03_result", {24'd0, result}, 32'd3);
        chk("t03_found", {31'd0, found}, 32'd1);
        chk("t03_steps", {28'd0, steps}, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
